sp_core: RTL and testbench

Scalar streaming-processor core for the GPU shader array: a 16×16-bit register file, a registered ALU result stage, a predicate flag, and a write-back mux. All sequencing comes from the external controller through `aluc`, `s2`, `reg_we` and the register selects. Each core receives a unique `CORE_ID` and the array size `N_CORES` as parameters, and exposes memory address and store data for `STORE`/`LOAD` instructions.

---
 rtl/sp_core.sv | 99 +++++++++
 tb/tb_sp_core.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sp_core.sv
// Scalar streaming-processor core: 16x16 register file, registered ALU result A,
// predicate P and write-back mux. Optional MAD (aluc 0011) enabled by SPCORE_MAD_EN.
module sp_core #(
    parameter int CORE_ID = 0,
    parameter int N_CORES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  x,
    input  logic [3:0]  y,
    input  logic [3:0]  z,
    input  logic [15:0] I,
    output logic        P,
    output logic [15:0] data_out,
    output logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        en,
    input  logic        reg_we,
    input  logic [3:0]  aluc,
    input  logic [1:0]  s2
);
    localparam logic [3:0] OP_CLEAR = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_MAD   = 4'b0011;
    localparam logic [3:0] OP_INC   = 4'b0100;
    localparam logic [3:0] OP_CID   = 4'b0101;
    localparam logic [3:0] OP_NCR   = 4'b0110;
    localparam logic [3:0] OP_EQ    = 4'b1000;
    localparam logic [3:0] OP_NEQ   = 4'b1001;
    localparam logic [3:0] OP_LT    = 4'b1010;
    localparam logic [3:0] OP_GT    = 4'b1011;

    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_I   = 2'b01;
    localparam logic [1:0] MUX_MEM = 2'b10;

    logic [15:0] regs_q [16];
    logic [15:0] a_q, a_d;
    logic        p_q, p_d;
    logic [15:0] rx, ry, rz, prod, wb_d;

    assign rx       = regs_q[x];
    assign ry       = regs_q[y];
    assign rz       = regs_q[z];
    assign data_out = rx;
    assign addr     = ry;
    assign P        = p_q;
    assign prod     = ry * rz;

    always_comb begin
        a_d = '0;
        p_d = p_q;
        case (aluc)
            OP_CLEAR: a_d = '0;
            OP_ADD:   a_d = ry + rz;
            OP_MUL:   a_d = prod;
`ifdef SPCORE_MAD_EN
            OP_MAD:   a_d = rx + prod;
`endif
            OP_INC:   a_d = rx + 16'd1;
            OP_CID:   a_d = 16'(CORE_ID);
            OP_NCR:   a_d = 16'(N_CORES);
            // compares update only the predicate; A keeps its value
            OP_EQ:    begin a_d = a_q; p_d = (rx == ry); end
            OP_NEQ:   begin a_d = a_q; p_d = (rx != ry); end
            OP_LT:    begin a_d = a_q; p_d = (rx <  ry); end
            OP_GT:    begin a_d = a_q; p_d = (rx >  ry); end
            default:  a_d = '0;
        endcase
    end

    always_comb begin
        case (s2)
            MUX_I:   wb_d = I;
            MUX_MEM: wb_d = data_in;
            default: wb_d = a_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            p_q <= 1'b0;
        end else if (en) begin
            a_q <= a_d;
            p_q <= p_d;
        end
    end

    // Write uses the pre-edge A, so an ALU write-back lands exactly once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else if (en && reg_we) begin
            regs_q[x] <= wb_d;
        end
    end
endmodule

// File: tb/tb_sp_core.sv
// Scoreboard bench for sp_core: stimulus pushes expected values, a negedge monitor
// pops and compares whenever a probe strobe is presented.
module tb_sp_core;
    logic        clk = 0;
    logic        reset = 0;
    logic [3:0]  x = 0, y = 0, z = 0, aluc = 0;
    logic [15:0] I = 0, data_in = 0;
    logic        en = 0, reg_we = 0;
    logic [1:0]  s2 = 0;
    logic        P;
    logic [15:0] data_out, addr;

    sp_core #(.CORE_ID(100), .N_CORES(200)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .z(z), .I(I), .P(P),
        .data_out(data_out), .addr(addr), .data_in(data_in), .en(en),
        .reg_we(reg_we), .aluc(aluc), .s2(s2)
    );

    always #5 clk = ~clk;

    typedef struct { int kind; logic [15:0] exp; string name; } exp_t;
    exp_t sb[$];
    logic chk = 0;
    int checks = 0, failures = 0;

`ifdef SPCORE_MAD_EN
    localparam logic [15:0] MAD_EXP = 16'd251;
`else
    localparam logic [15:0] MAD_EXP = 16'd0;
`endif

    // kind 0: data_out (R[x]), 1: addr (R[y]), 2: P
    always @(negedge clk) begin
        if (chk) begin
            exp_t e;
            logic [15:0] act;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty: probe with no expected value");
            end else begin
                e = sb.pop_front();
                act = (e.kind == 0) ? data_out : (e.kind == 1) ? addr : {15'b0, P};
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic op(input logic e_, we, input logic [3:0] c, input logic [1:0] s,
                      input logic [3:0] xs, ys, zs, input logic [15:0] imm);
        @(posedge clk); #1;
        chk = 0; en = e_; reg_we = we; aluc = c; s2 = s;
        x = xs; y = ys; z = zs; I = imm;
    endtask

    // execute then write back the ALU result into R[xs]
    task automatic alu(input logic [3:0] c, xs, ys, zs);
        op(1, 0, c, 2'b00, xs, ys, zs, 0);
        op(1, 1, c, 2'b00, xs, ys, zs, 0);
    endtask

    task automatic loadi(input logic [3:0] xs, input logic [15:0] imm);
        op(1, 1, 4'b0000, 2'b01, xs, 0, 0, imm);
    endtask

    task automatic probe(input int kind, input logic [3:0] sel, input logic [15:0] e,
                         input string nm);
        exp_t t;
        @(posedge clk); #1;
        en = 0; reg_we = 0;
        if (kind == 1) y = sel; else x = sel;
        t.kind = kind; t.exp = e; t.name = nm;
        sb.push_back(t);
        chk = 1;
    endtask

    initial begin
        probe(0, 0, 0, "reset_R0");
        probe(2, 0, 0, "reset_P");
        @(posedge clk); #1; chk = 0; reset = 1;

        loadi(0, 11);
        loadi(1, 20);
        probe(0, 0, 11, "loadi_R0");
        probe(0, 1, 20, "loadi_R1");
        probe(0, 9, 0, "untouched_R9");
        probe(2, 0, 0, "P_after_load");

        alu(4'b0001, 2, 0, 1);
        probe(0, 2, 31, "add_R2");
        alu(4'b0011, 2, 0, 1);
        probe(0, 2, MAD_EXP, "mad_R2");
        alu(4'b0010, 2, 0, 1);
        probe(0, 2, 220, "mul_R2");

        alu(4'b0101, 3, 0, 0);
        probe(0, 3, 100, "core_id_R3");
        alu(4'b0110, 3, 0, 0);
        probe(0, 3, 200, "n_cores_R3");
        alu(4'b0000, 3, 0, 0);
        probe(0, 3, 0, "clear_R3");
        alu(4'b0100, 3, 0, 0);
        probe(0, 3, 1, "inc_R3");

        loadi(4, 16'hFFFF);
        alu(4'b0100, 4, 0, 0);
        probe(0, 4, 0, "inc_wrap_R4");
        loadi(5, 16'h0100);
        loadi(6, 7);
        alu(4'b0010, 6, 5, 5);
        probe(0, 6, 0, "mul_wrap_R6");

        // undefined code clears A; write back via s2=11
        op(1, 0, 4'b0001, 2'b00, 7, 0, 1, 0);
        op(1, 0, 4'b0111, 2'b00, 7, 0, 1, 0);
        op(1, 1, 4'b0111, 2'b11, 7, 0, 1, 0);
        probe(0, 7, 0, "undef_R7");

        data_in = 16'hBEEF;
        op(1, 1, 4'b0000, 2'b10, 8, 0, 0, 0);
        probe(0, 8, 16'hBEEF, "load_mem_R8");

        op(1, 0, 4'b1001, 2'b00, 1, 1, 0, 0);
        probe(2, 0, 0, "neq_P");
        op(1, 0, 4'b1000, 2'b00, 1, 1, 0, 0);
        probe(2, 0, 1, "eq_P");
        op(1, 0, 4'b1011, 2'b00, 0, 1, 0, 0);
        probe(2, 0, 0, "gt_P");
        op(1, 0, 4'b1010, 2'b00, 0, 1, 0, 0);
        probe(2, 0, 1, "lt_P");
        alu(4'b0001, 9, 0, 1);
        probe(2, 0, 1, "add_keeps_P");
        probe(0, 9, 31, "add_R9");

        op(0, 1, 4'b0000, 2'b01, 0, 0, 0, 999);
        op(0, 1, 4'b0000, 2'b01, 0, 0, 0, 999);
        probe(0, 0, 11, "en0_R0");
        probe(1, 1, 20, "addr_R1");
        probe(1, 2, 220, "addr_R2");

        op(1, 0, 4'b0001, 2'b00, 10, 0, 1, 0);
        op(1, 1, 4'b0001, 2'b00, 10, 0, 1, 0);
        #2 reset = 0;
        probe(0, 0, 0, "rst_R0");
        probe(0, 10, 0, "rst_R10");
        probe(1, 1, 0, "rst_addr_R1");
        probe(2, 0, 0, "rst_P");

        @(posedge clk); #1; chk = 0;
        @(negedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
